fpu_to_int: RTL and testbench
=============================

# fpu_to_int

Multi-cycle converter from the team's 32-bit float format to a 32-bit two's-complement signed integer. It is the consumer-side counterpart of the FPU adder, which produces float words. It sits downstream of the FPU on the 100 kHz clock domain and accepts one operand per start/done transaction. Alignment uses a one-bit-per-cycle shifter, then the block rounds, saturates and reports status with the FPU's one-hot status code.

## Interface
- No parameters. Format is fixed:
  - sign = bit 31
  - exp = bits 30:25, unsigned, bias 31
  - mant = bits 24:0, implicit leading 1
  - value = (-1)^sign × 1.mant × 2^(exp−31)
- clock100KHz  in  1  sole clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- start  in  1  request; sampled only in IDLE.
- op_in  in  32  float operand; captured on the accepting edge and ignored afterwards.
- busy  out  1  high from the accepting edge until done is asserted.
- done  out  1  one-cycle pulse; data_out and status_out are valid from this cycle on.
- data_out  out  32  signed integer result; held until the next done.
- status_out  out  4  one-hot status, held until the next done:
  - EXACT 0001
  - INEXACT 0010
  - OVERFLOW 0100
  - UNDERFLOW 1000

## Operation
- States: IDLE, ALIGN, ROUND.
- **IDLE**, start=1: capture the operand, then go to ALIGN with busy=1. Working registers:
  - sign
  - sig = {1, mant}, 26 bits, widened to a 32-bit shift register
  - guard and sticky bits, both cleared
  - direction and count, set by exp class:
    - exp = 0: result 0, count = 0. Status is EXACT if mant = 0, else UNDERFLOW.
    - 1 ≤ exp ≤ 29: result 0, count = 0, UNDERFLOW. The value is below 0.5 and rounds to 0.
    - 30 ≤ exp ≤ 55: right shift, count = 56 − exp (range 1..26).
    - exp = 56: count = 0, no shift.
    - 57 ≤ exp ≤ 61: left shift, count = exp − 56 (range 1..5).
    - exp ≥ 62: count = 0. If sign=1, exp=62 and mant=0, the result is 0x80000000 EXACT. Otherwise the result saturates with OVERFLOW.
- **ALIGN**: while count ≠ 0, shift one bit and decrement count each cycle.
  - Right shift: sticky |= guard; guard ← LSB.
  - Left shift inserts 0.
  - When count = 0, go to ROUND.
- **ROUND**:
  - Magnitude = shift register + guard (round half away from zero).
  - Apply sign by two's-complement negation when sign=1.
  - Overflow check on the rounded magnitude:
    - sign=0: magnitude > 0x7FFFFFFF saturates to 0x7FFFFFFF, OVERFLOW.
    - sign=1: magnitude > 0x80000000 saturates to 0x80000000, OVERFLOW.
  - Status priority: OVERFLOW > UNDERFLOW > INEXACT (guard|sticky) > EXACT.
  - A zero result is never negative; −0 input gives 0x00000000.
  - On the ROUND edge: register data_out and status_out, pulse done, clear busy, go to IDLE.
- start while busy is ignored; no queuing.
- Any undefined state encoding returns to IDLE.

## Timing
- Reset values (asynchronous): state IDLE; busy 0; done 0; data_out 0x00000000; status_out 0000; all working registers 0.
- Reset asserted mid-conversion aborts the conversion, produces no done, and leaves outputs at their reset values.
- Latency: start is sampled at edge E. done is high in the cycle after edge E+n+2, where n = count (0..26). That is n+3 cycles from the start cycle to the done cycle.
  - Minimum latency is 3 cycles (special cases, exp 56); maximum is 29 cycles (exp 30).
- done is high for exactly one cycle. busy drops on the same edge that raises done.
- A new start may be sampled in the cycle where done=1, since the state is already IDLE. Back-to-back throughput is one conversion per n+3 cycles.

## Test plan
- 0x3E000000 (1.0) -> data_out 0x00000001, EXACT; done 28 cycles after start (n=25).
- 0x40800000 (2.5) -> 0x00000003, INEXACT; 0xBF000000 (−1.5) -> 0xFFFFFFFE, INEXACT.
- 0xFC000000 (−2^31) -> 0x80000000, EXACT. 0x7C000000 (+2^31) -> 0x7FFFFFFF, OVERFLOW. 0xFE000000 -> 0x80000000, OVERFLOW. All three finish in 3 cycles.
- 0x00000000 -> 0, EXACT, 3 cycles. 0x00000001 -> 0, UNDERFLOW. 0x28000000 (exp 20) -> 0, UNDERFLOW. 0x3C000000 (0.5) -> 0x00000001, INEXACT, 29 cycles.
- Pulse start again during busy with a different op_in -> the second start is ignored and the first result is returned intact. Then start in the done cycle -> accepted, with the correct second result.
- Assert reset mid-ALIGN -> busy, done, data_out and status_out go to 0 at once. After release, a fresh conversion of 0x7A000000 (2^30) -> 0x40000000, EXACT.

Source files
------------

// File: rtl/fpu_to_int.sv
// Float (1/6/25, bias 31) to 32-bit signed integer converter.
// Aligns one bit per cycle, then rounds half away from zero and saturates.
module fpu_to_int (
   input  logic        clock100KHz,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] op_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] data_out,
   output logic [3:0]  status_out
);

   localparam logic [3:0] ST_EXACT     = 4'b0001;
   localparam logic [3:0] ST_INEXACT   = 4'b0010;
   localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
   localparam logic [3:0] ST_UNDERFLOW = 4'b1000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      ROUND = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic        sign_r;
   logic [31:0] sr_r;
   logic        guard_r;
   logic        sticky_r;
   logic        left_r;
   logic [4:0]  count_r;
   logic        force_r;
   logic [31:0] force_data_r;
   logic [3:0]  force_stat_r;

   logic        op_sign;
   logic [5:0]  op_exp;
   logic [24:0] op_mant;

   logic        dec_left;
   logic [4:0]  dec_count;
   logic        dec_force;
   logic [31:0] dec_data;
   logic [3:0]  dec_stat;

   logic [32:0]        rnd_mag;
   logic               rnd_ovf;
   logic signed [31:0] rnd_int;
   logic [31:0]        rnd_data;
   logic [3:0]         rnd_stat;

   function automatic logic [32:0] round_mag(input logic [31:0] sr, input logic guard);
      return {1'b0, sr} + {32'd0, guard};
   endfunction

   function automatic logic is_ovf(input logic sign, input logic [32:0] mag);
      return sign ? (mag > 33'h0_8000_0000) : (mag > 33'h0_7FFF_FFFF);
   endfunction

   function automatic logic signed [31:0] sat_int(input logic sign, input logic [32:0] mag);
      logic signed [31:0] v;
      if (is_ovf(sign, mag))
         v = sign ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
      else if (sign)
         v = -$signed(mag[31:0]);
      else
         v = $signed(mag[31:0]);
      return v;
   endfunction

   function automatic logic [3:0] round_status(input logic ovf, input logic lost);
      logic [3:0] s;
      if (ovf)
         s = ST_OVERFLOW;
      else if (lost)
         s = ST_INEXACT;
      else
         s = ST_EXACT;
      return s;
   endfunction

   assign op_sign = op_in[31];
   assign op_exp  = op_in[30:25];
   assign op_mant = op_in[24:0];

   // Classify the exponent: shift direction/count, or a result fixed at capture time.
   always_comb begin
      dec_left  = 1'b0;
      dec_count = 5'd0;
      dec_force = 1'b0;
      dec_data  = 32'd0;
      dec_stat  = ST_EXACT;
      if (op_exp == 6'd0) begin
         dec_force = 1'b1;
         dec_stat  = (op_mant == 25'd0) ? ST_EXACT : ST_UNDERFLOW;
      end else if (op_exp <= 6'd29) begin
         dec_force = 1'b1;
         dec_stat  = ST_UNDERFLOW;
      end else if (op_exp <= 6'd55) begin
         dec_count = 5'(6'd56 - op_exp);
      end else if (op_exp == 6'd56) begin
         dec_count = 5'd0;
      end else if (op_exp <= 6'd61) begin
         dec_left  = 1'b1;
         dec_count = 5'(op_exp - 6'd56);
      end else begin
         dec_force = 1'b1;
         if (op_sign && (op_exp == 6'd62) && (op_mant == 25'd0)) begin
            dec_data = 32'h8000_0000;
            dec_stat = ST_EXACT;
         end else begin
            dec_data = op_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            dec_stat = ST_OVERFLOW;
         end
      end
   end

   always_comb begin
      rnd_mag = round_mag(sr_r, guard_r);
      rnd_ovf = is_ovf(sign_r, rnd_mag);
      rnd_int = sat_int(sign_r, rnd_mag);
      if (force_r) begin
         rnd_data = force_data_r;
         rnd_stat = force_stat_r;
      end else begin
         rnd_data = rnd_int;
         rnd_stat = round_status(rnd_ovf, guard_r | sticky_r);
      end
   end

   always_ff @(posedge clock100KHz or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ALIGN;
         ALIGN:   if (count_r == 5'd0) state_nxt = ROUND;
         ROUND:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clock100KHz or negedge reset) begin
      if (!reset) begin
         sign_r       <= 1'b0;
         sr_r         <= 32'd0;
         guard_r      <= 1'b0;
         sticky_r     <= 1'b0;
         left_r       <= 1'b0;
         count_r      <= 5'd0;
         force_r      <= 1'b0;
         force_data_r <= 32'd0;
         force_stat_r <= 4'd0;
         done         <= 1'b0;
         data_out     <= 32'd0;
         status_out   <= 4'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sign_r       <= op_sign;
                  sr_r         <= {6'd0, 1'b1, op_mant};
                  guard_r      <= 1'b0;
                  sticky_r     <= 1'b0;
                  left_r       <= dec_left;
                  count_r      <= dec_count;
                  force_r      <= dec_force;
                  force_data_r <= dec_data;
                  force_stat_r <= dec_stat;
               end
            end
            ALIGN: begin
               // Right shifts keep the last bit out as guard and OR older ones into sticky.
               if (count_r != 5'd0) begin
                  count_r <= count_r - 5'd1;
                  if (left_r) begin
                     sr_r <= {sr_r[30:0], 1'b0};
                  end else begin
                     sr_r     <= {1'b0, sr_r[31:1]};
                     guard_r  <= sr_r[0];
                     sticky_r <= sticky_r | guard_r;
                  end
               end
            end
            ROUND: begin
               data_out   <= rnd_data;
               status_out <= rnd_stat;
               done       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_to_int.sv
// Randomised self-checking bench for fpu_to_int against an arithmetic reference model.
`timescale 1ns/1ps
module tb_fpu_to_int;

   logic        clock100KHz;
   logic        reset;
   logic        start;
   logic [31:0] op_in;
   logic        busy;
   logic        done;
   logic [31:0] data_out;
   logic [3:0]  status_out;

   fpu_to_int dut (
      .clock100KHz(clock100KHz),
      .reset      (reset),
      .start      (start),
      .op_in      (op_in),
      .busy       (busy),
      .done       (done),
      .data_out   (data_out),
      .status_out (status_out)
   );

   initial clock100KHz = 1'b0;
   always #5000 clock100KHz = ~clock100KHz;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  stat;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] held_data = 32'd0;
   logic [3:0]  held_stat = 4'd0;
   exp_t        mon_e;
   logic        mon_done;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Value = sig * 2^(exp-56); round half away from zero, then saturate.
   function automatic exp_t model(input logic [31:0] op);
      exp_t   r;
      logic   s;
      int     e;
      longint sig, mag, quo, rem, half;
      bit     inexact;
      int     k;
      s   = op[31];
      e   = int'(op[30:25]);
      sig = longint'({1'b1, op[24:0]});
      r.acc = 0;
      if (e >= 30 && e <= 55)      r.lat = (56 - e) + 3;
      else if (e >= 57 && e <= 61) r.lat = (e - 56) + 3;
      else                         r.lat = 3;
      if (e == 0) begin
         r.data = 32'd0;
         r.stat = (op[24:0] == 25'd0) ? 4'b0001 : 4'b1000;
         return r;
      end
      if (e >= 56) begin
         mag     = sig << (e - 56);
         inexact = 1'b0;
      end else begin
         k       = 56 - e;
         quo     = sig >> k;
         rem     = sig - (quo << k);
         half    = longint'(1) << (k - 1);
         mag     = quo + ((rem >= half) ? longint'(1) : longint'(0));
         inexact = (rem != 0);
      end
      if (!s && mag > 64'h7FFF_FFFF) begin
         r.data = 32'h7FFF_FFFF; r.stat = 4'b0100;
      end else if (s && mag > 64'h8000_0000) begin
         r.data = 32'h8000_0000; r.stat = 4'b0100;
      end else if (mag == 0) begin
         r.data = 32'd0; r.stat = 4'b1000;
      end else begin
         r.data = s ? 32'(-mag) : 32'(mag);
         r.stat = inexact ? 4'b0010 : 4'b0001;
      end
      return r;
   endfunction

   always @(posedge clock100KHz) begin
      #1;
      cyc++;
      if (reset) begin
         mon_done = (exp_q.size() != 0) && ((cyc - exp_q[0].acc + 1) == exp_q[0].lat);
         chk("done", 64'(done), 64'(mon_done));
         if (mon_done) begin
            mon_e     = exp_q.pop_front();
            held_data = mon_e.data;
            held_stat = mon_e.stat;
         end
         chk("data_out", 64'(data_out), 64'(held_data));
         chk("status_out", 64'(status_out), 64'(held_stat));
         chk("busy", 64'(busy), 64'(exp_q.size() != 0));
      end
   end

   task automatic issue(input logic [31:0] op, input bit now);
      exp_t e;
      e = model(op);
      if (!now) @(negedge clock100KHz);
      start = 1'b1;
      op_in = op;
      e.acc = cyc + 1;
      exp_q.push_back(e);
      @(negedge clock100KHz);
      start = 1'b0;
      op_in = $urandom;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clock100KHz);
         t++;
      end
      if (exp_q.size() != 0) begin
         chk("idle_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      do begin
         @(negedge clock100KHz);
         t++;
      end while (!done && t < 100);
      if (!done) chk("done_timeout", 64'(done), 64'd1);
   endtask

   logic [31:0] plan_op   [13] = '{32'h3E000000, 32'h40800000, 32'hBF000000, 32'hFC000000,
                                   32'h7C000000, 32'hFE000000, 32'h00000000, 32'h00000001,
                                   32'h28000000, 32'h3C000000, 32'h7A000000, 32'h70000000,
                                   32'h80000000};
   logic [31:0] plan_data [13] = '{32'h00000001, 32'h00000003, 32'hFFFFFFFE, 32'h80000000,
                                   32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h00000000,
                                   32'h00000000, 32'h00000001, 32'h40000000, 32'h02000000,
                                   32'h00000000};
   logic [3:0]  plan_stat [13] = '{4'b0001, 4'b0010, 4'b0010, 4'b0001, 4'b0100, 4'b0100,
                                   4'b0001, 4'b1000, 4'b1000, 4'b0010, 4'b0001, 4'b0001,
                                   4'b0001};
   int          plan_lat  [13] = '{28, 27, 28, 3, 3, 3, 3, 3, 3, 29, 8, 3, 3};

   int          bexp [10] = '{0, 29, 30, 31, 55, 56, 57, 61, 62, 63};

   initial begin
      exp_t        m;
      logic [31:0] op;
      int          ex;
      int          gap;
      reset = 1'b0;
      start = 1'b0;
      op_in = 32'd0;
      repeat (3) @(negedge clock100KHz);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_data", 64'(data_out), 64'd0);
      chk("reset_status", 64'(status_out), 64'd0);

      for (int i = 0; i < 13; i++) begin
         m = model(plan_op[i]);
         chk($sformatf("model_data_%08h", plan_op[i]), 64'(m.data), 64'(plan_data[i]));
         chk($sformatf("model_stat_%08h", plan_op[i]), 64'(m.stat), 64'(plan_stat[i]));
         chk($sformatf("model_lat_%08h", plan_op[i]), 64'(m.lat), 64'(plan_lat[i]));
      end

      reset = 1'b1;
      repeat (2) @(negedge clock100KHz);

      for (int i = 0; i < 13; i++) begin
         wait_idle();
         issue(plan_op[i], 1'b0);
      end

      // Start during busy is ignored; start in the done cycle is accepted.
      wait_idle();
      issue(32'h3C000000, 1'b0);
      repeat (5) @(negedge clock100KHz);
      start = 1'b1;
      op_in = 32'hBF000000;
      @(negedge clock100KHz);
      start = 1'b0;
      wait_done();
      issue(32'hBF000000, 1'b1);
      wait_idle();

      // Asynchronous reset in the middle of alignment.
      issue(32'h3E000000, 1'b0);
      repeat (8) @(negedge clock100KHz);
      reset = 1'b0;
      exp_q.delete();
      held_data = 32'd0;
      held_stat = 4'd0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_data", 64'(data_out), 64'd0);
      chk("abort_status", 64'(status_out), 64'd0);
      repeat (2) @(negedge clock100KHz);
      reset = 1'b1;
      issue(32'h7A000000, 1'b0);
      wait_done();
      chk("post_reset_data", 64'(data_out), 64'h40000000);
      chk("post_reset_status", 64'(status_out), 64'b0001);
      wait_idle();

      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 9) < 3) ex = bexp[$urandom_range(0, 9)];
         else                          ex = $urandom_range(0, 63);
         op[31]    = 1'($urandom_range(0, 1));
         op[30:25] = 6'(ex);
         op[24:0]  = ($urandom_range(0, 3) == 0) ? 25'd0 : 25'($urandom);
         gap = $urandom_range(0, 3);
         if (gap == 0 && exp_q.size() != 0) begin
            wait_done();
            issue(op, 1'b1);
         end else begin
            wait_idle();
            repeat (gap) @(negedge clock100KHz);
            issue(op, 1'b0);
         end
      end
      wait_idle();
      repeat (3) @(negedge clock100KHz);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
